// File: rtl/addr_serial_pkg.sv
// Shared definitions for the digit-serial adder.
//   state_t   : controller state encoding (IDLE, RUN, DONE)
//   mod3      : residue modulo 3 of a value of up to 64 bits
//   mod3_add  : (x + y) mod 3 for two residues
package addr_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned RES_MAX_W = 64;

    // MSB-first Horner evaluation: r = (2*r + bit) mod 3.
    function automatic logic [1:0] mod3(input logic [RES_MAX_W-1:0] v);
        logic [1:0] r;
        r = '0;
        for (int unsigned i = RES_MAX_W; i > 0; i--) begin
            r = 2'({r, v[i-1]} % 3'd3);
        end
        return r;
    endfunction

    function automatic logic [1:0] mod3_add(input logic [1:0] x, input logic [1:0] y);
        return 2'(({1'b0, x} + {1'b0, y}) % 3'd3);
    endfunction

endpackage

// File: rtl/addr_digit_slice.sv
// Combinational DIGIT-bit adder slice.
//   a, b : DIGIT-bit operand digits
//   cin  : carry in
//   s    : DIGIT-bit digit sum
//   cout : carry out
module addr_digit_slice #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
);

    always_comb begin
        {cout, s} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
    end

endmodule

// File: rtl/addr_serial_ft.sv
// Digit-serial unsigned adder with optional mod-3 residue check.
// Adds DIGIT bits per clock; a result appears WIDTH/DIGIT cycles after accept.
// Optional feature macro: ADDR_RESIDUE_CHECK_EN (residue check driving err).
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (a, b)
//   out_valid/out_ready : result handshake (sum, err)
//   sum                 : WIDTH+1 bit sum, MSB is carry-out
//   err                 : residue mismatch for the held result
module addr_serial_ft #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             err
);
    import addr_serial_pkg::*;

    localparam int NDIG = (DIGIT >= 1) ? WIDTH / DIGIT : 1;
    localparam int CW   = $clog2(NDIG + 1);

    if (DIGIT < 1 || DIGIT > WIDTH) begin : g_bad_digit
        $error("addr_serial_ft: DIGIT must be within 1..WIDTH");
    end else if (WIDTH % DIGIT != 0) begin : g_bad_div
        $error("addr_serial_ft: WIDTH must be a multiple of DIGIT");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH:0]   sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DIGIT-1:0] dig_s;
    logic             dig_cout;
    logic [WIDTH-1:0] sum_shift;

    addr_digit_slice #(.DIGIT(DIGIT)) u_slice (
        .a    (a_q[DIGIT-1:0]),
        .b    (b_q[DIGIT-1:0]),
        .cin  (carry_q),
        .s    (dig_s),
        .cout (dig_cout)
    );

    // New digit enters at the top; with a single digit it is the whole word.
    if (DIGIT == WIDTH) begin : g_one_digit
        assign sum_shift = dig_s;
    end else begin : g_multi_digit
        assign sum_shift = {dig_s, sum_q[WIDTH-1:DIGIT]};
    end

`ifdef ADDR_RESIDUE_CHECK_EN
    if (WIDTH + 1 > RES_MAX_W) begin : g_bad_res_width
        $error("addr_serial_ft: residue check supports WIDTH up to 63");
    end

    logic       err_q, err_d;
    logic [1:0] res_q, res_d;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
`ifdef ADDR_RESIDUE_CHECK_EN
        err_d   = err_q;
        res_d   = res_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef ADDR_RESIDUE_CHECK_EN
                    err_d   = 1'b0;
                    res_d   = mod3_add(mod3(RES_MAX_W'(a)), mod3(RES_MAX_W'(b)));
`endif
                end
            end
            RUN: begin
                sum_d   = {dig_cout, sum_shift};
                carry_d = dig_cout;
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(NDIG - 1)) begin
                    state_d = DONE;
`ifdef ADDR_RESIDUE_CHECK_EN
                    err_d   = (mod3(RES_MAX_W'(sum_d)) != res_q);
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
`ifdef ADDR_RESIDUE_CHECK_EN
            err_q   <= 1'b0;
            res_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
`ifdef ADDR_RESIDUE_CHECK_EN
            err_q   <= err_d;
            res_q   <= res_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
`ifdef ADDR_RESIDUE_CHECK_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_addr_serial_ft.sv
// Directed testbench for addr_serial_ft: default 8/2 instance plus a 16/4 instance.
module tb_addr_serial_ft;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, err;
    logic [7:0] a, b;
    logic [8:0] sum;

    logic        iv16, ir16, ov16, or16, err16;
    logic [15:0] a16, b16;
    logic [16:0] sum16;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    addr_serial_ft dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .err(err)
    );

    addr_serial_ft #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .out_valid(ov16), .out_ready(or16),
        .sum(sum16), .err(err16)
    );

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic [8:0] exp_sum;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Wait (bounded) for out_valid on dut8; returns cycles counted.
    task automatic wait_ov8(input int start, output int lat);
        lat = start;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_op8(input string nm, input logic [7:0] va, input logic [7:0] vb,
                          input logic [8:0] exp_sum);
        int lat;
        @(negedge clk);
        check({nm, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; a = va; b = vb;
        @(posedge clk); #1;
        in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom);
        wait_ov8(0, lat);
        check({nm, ".latency"}, 32'(lat), 32'd4);
        check({nm, ".sum"}, 32'(sum), 32'(exp_sum));
        check({nm, ".err"}, 32'(err), 32'd0);
        check({nm, ".busy"}, 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({nm, ".release"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    task automatic do_op16(input string nm, input logic [15:0] va, input logic [15:0] vb,
                           input logic [16:0] exp_sum);
        int lat;
        @(negedge clk);
        iv16 = 1'b1; a16 = va; b16 = vb;
        @(posedge clk); #1;
        iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
        lat = 0;
        while (ov16 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, ".latency"}, 32'(lat), 32'd4);
        check({nm, ".sum"}, 32'(sum16), 32'(exp_sum));
        or16 = 1'b1;
        @(posedge clk); #1;
        or16 = 1'b0;
        check({nm, ".release"}, {30'd0, ov16, ir16}, 32'b01);
    endtask

    initial begin
        int lat;
        int spurious;

        vecs[0] = '{8'hFF, 8'hFF, 9'h1FE};
        vecs[1] = '{8'h00, 8'h00, 9'h000};
        vecs[2] = '{8'h80, 8'h80, 9'h100};
        vecs[3] = '{8'h01, 8'h01, 9'h002};
        vecs[4] = '{8'h55, 8'hAA, 9'h0FF};
        vecs[5] = '{8'h0F, 8'hF1, 9'h100};
        vecs[6] = '{8'h3C, 8'hC3, 9'h0FF};
        vecs[7] = '{8'h7F, 8'h01, 9'h080};
        vecs[8] = '{8'hA5, 8'h5A, 9'h0FF};
        vecs[9] = '{8'h12, 8'h34, 9'h046};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        iv16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset8", {20'd0, out_valid, in_ready, err, sum}, {20'd0, 1'b0, 1'b1, 1'b0, 9'h000});
        check("reset16", {12'd0, ov16, ir16, err16, sum16}, {12'd0, 1'b0, 1'b1, 1'b0, 17'h00000});
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_op8($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].exp_sum);
        end

        // Backpressure: result held in DONE; new operands ignored until back in IDLE.
        @(negedge clk);
        in_valid = 1'b1; a = 8'h3C; b = 8'h0F;
        @(posedge clk); #1;
        a = 8'h11; b = 8'h22;
        wait_ov8(0, lat);
        check("hold.latency", 32'(lat), 32'd4);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check($sformatf("hold.cyc%0d", i), {21'd0, out_valid, in_ready, sum},
                  {21'd0, 1'b1, 1'b0, 9'h04B});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("hold.no_accept_on_release", {30'd0, out_valid, in_ready}, 32'b01);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("hold.accept_next", 32'(in_ready), 32'd0);
        wait_ov8(0, lat);
        check("hold.next.latency", 32'(lat), 32'd4);
        check("hold.next.sum", 32'(sum), 32'h033);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset during the second RUN cycle discards the operation.
        @(negedge clk);
        in_valid = 1'b1; a = 8'hFF; b = 8'hFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid.state", {20'd0, out_valid, in_ready, err, sum},
              {20'd0, 1'b0, 1'b1, 1'b0, 9'h000});
        spurious = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) spurious++;
        end
        check("rst_mid.no_result", 32'(spurious), 32'd0);

        // Carry corrupted for one RUN cycle of FF+01: sum becomes 0FC.
        @(negedge clk);
        in_valid = 1'b1; a = 8'hFF; b = 8'h01;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        force dut8.carry_q = 1'b0;
        @(posedge clk); #1;
        release dut8.carry_q;
        wait_ov8(2, lat);
        check("fault.latency", 32'(lat), 32'd4);
        check("fault.sum", 32'(sum), 32'h0FC);
`ifdef ADDR_RESIDUE_CHECK_EN
        check("fault.err", 32'(err), 32'd1);
`else
        check("fault.err", 32'(err), 32'd0);
`endif
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        do_op16("w16.ffff_0001", 16'hFFFF, 16'h0001, 17'h10000);
        do_op16("w16.1234_4321", 16'h1234, 16'h4321, 17'h05555);
        do_op16("w16.ffff_ffff", 16'hFFFF, 16'hFFFF, 17'h1FFFE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/addr_serial_ft.md
ADDR_SERIAL_FT -- requirements
Module: addr_serial_ft

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits.
REQ-002 SHALL have parameter DIGIT, default 2, bits added per clock cycle.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operands a/b presented.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  WIDTH  unsigned operand A.
REQ-008 SHALL have port b  input  WIDTH  unsigned operand B.
REQ-009 SHALL have port out_valid  output  1  sum/err valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port sum  output  WIDTH+1  unsigned A+B, MSB is carry-out.
REQ-012 SHALL have port err  output  1  residue-check mismatch for the current result.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; NDIG = WIDTH/DIGIT.
REQ-014 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 On in_valid&&in_ready SHALL latch a, b into shift registers, clear carry, digit counter and err, and go to RUN.
REQ-016 Each RUN cycle SHALL add low DIGIT bits of both operand registers plus carry, shift the DIGIT-bit result into sum from the MSB side, update carry, shift operands right by DIGIT, increment counter.
REQ-017 After the NDIG-th RUN cycle SHALL enter DONE with sum[WIDTH] = final carry; out_valid rises exactly NDIG cycles after the accept edge (default: 4).
REQ-018 In DONE SHALL hold sum and err stable until out_valid&&out_ready, then return to IDLE; no operand accepted on that same edge (min. NDIG+2 cycles per operation).
REQ-019 SHALL ignore a, b and in_valid outside IDLE.
REQ-020 Counter SHALL be ceil(log2(NDIG+1)) bits wide and never wrap; NDIG=1 (DIGIT=WIDTH) SHALL be legal.
REQ-021 Elaboration SHALL fail if DIGIT<1, DIGIT>WIDTH, or WIDTH mod DIGIT != 0.

Reset
REQ-022 rst=1 SHALL, at the next clock edge, force IDLE, sum=0, err=0, carry=0, counter=0, out_valid=0, in_ready=1, regardless of state.
REQ-023 rst mid-RUN or in DONE SHALL discard the operation with no result delivered.

Configuration
REQ-024 Macro ADDR_RESIDUE_CHECK_EN, when defined, SHALL latch (a mod 3 + b mod 3) mod 3 at accept and, on entry to DONE, set err=1 iff it differs from sum mod 3.
REQ-025 Without ADDR_RESIDUE_CHECK_EN, err SHALL be constant 0 and no residue logic SHALL be synthesised.

Structure
REQ-026 Shared package addr_serial_pkg SHALL hold the FSM state enum typedef and the mod-3 residue function.
REQ-027 One sub-module addr_digit_slice (combinational DIGIT-bit adder: a, b, cin -> s, cout) SHALL be instantiated once.

Verification
REQ-028 Defaults: a=8'hFF, b=8'hFF accepted -> out_valid 4 cycles later, sum=9'h1FE, err=0.
REQ-029 a=0, b=0 -> sum=9'h000; a=8'h80, b=8'h80 -> sum=9'h100.
REQ-030 out_ready held 0 for 6 cycles in DONE -> sum/out_valid stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-031 rst asserted on second RUN cycle -> next edge out_valid=0, in_ready=1, sum=0; no result emitted.
REQ-032 WIDTH=16, DIGIT=4: a=16'hFFFF, b=16'h0001 -> sum=17'h10000 after 4 cycles.
REQ-033 With ADDR_RESIDUE_CHECK_EN, carry forced to 0 during one RUN cycle of 8'hFF+8'h01 -> err=1 with out_valid; without macro err=0.
